// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the multicycle MIPS memory responder.
//   state_e : responder FSM states (IDLE, WAIT, DONE)
//   op_e    : captured access type (OP_RD / OP_WR)
//   DEFAULT_IO_ADDR : byte address of the memory-mapped I/O register
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam logic [7:0] DEFAULT_IO_ADDR = 8'hFF;
  localparam int         MAX_WAIT_STATES = 15;
  localparam int         CNT_W           = 4;

endpackage

// File: rtl/mem_responder_if.sv
// Controller <-> memory bus of the multicycle MIPS core.
//   memread / memwrite : level request strobes from the controller
//   adr / writedata    : byte address and store data
//   memready           : one-cycle completion pulse from the memory side
//   readdata           : load / fetch result, held until the next read completes
// master = controller side, slave = memory responder side.
interface mem_responder_if #(
  parameter int AW = 8,
  parameter int DW = 8
);

  logic          memread;
  logic          memwrite;
  logic [AW-1:0] adr;
  logic [DW-1:0] writedata;
  logic          memready;
  logic [DW-1:0] readdata;

  modport master (
    output memread, memwrite, adr, writedata,
    input  memready, readdata
  );

  modport slave (
    input  memread, memwrite, adr, writedata,
    output memready, readdata
  );

endinterface

// File: rtl/byte_ram.sv
// Byte-wide RAM behind the memory responder.
//   clk   : clock
//   we    : synchronous write enable
//   addr  : shared read/write index
//   wdata : write data
//   rdata : combinational read of mem[addr]
// Contents are not reset.
module byte_ram #(
  parameter int  DW    = 8,
  parameter int  DEPTH = 256,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the 8-bit multicycle MIPS core.
// Services instruction fetches, LB reads and SB writes against a byte RAM
// with WAIT_STATES programmable wait cycles and one memory-mapped I/O
// register at IO_ADDR.
//   clk, rst : clock, synchronous active-high reset
//   bus      : controller bus (slave modport): memread, memwrite, adr,
//              writedata in; memready pulse and registered readdata out
//   io_in    : external input, returned on reads of IO_ADDR
//   io_out   : external output register, written by stores to IO_ADDR
//   err      : sticky flag, set when memread and memwrite are both high at
//              capture; clears only on rst
module mem_responder
  import mips_mem_pkg::*;
#(
  parameter int          AW          = 8,
  parameter int          DW          = 8,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 0,
  parameter logic [AW-1:0] IO_ADDR   = AW'(DEFAULT_IO_ADDR)
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_responder_if.slave        bus,
  input  logic [DW-1:0]         io_in,
  output logic [DW-1:0]         io_out,
  output logic                  err
);

  localparam int IW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH > (1 << AW)) begin : g_bad_depth
    $error("mem_responder: DEPTH must be a power of two in 2..2^AW");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait
    $error("mem_responder: WAIT_STATES must be 0..15");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      adr_q, adr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  op_e                op_q, op_d;
  logic               memready_q, memready_d;
  logic [DW-1:0]      readdata_q, readdata_d;
  logic [DW-1:0]      io_out_q, io_out_d;
  logic               err_q, err_d;

  logic               req;
  logic               commit;
  logic               is_io;
  logic               ram_we;
  logic [DW-1:0]      ram_rdata;

  // Next-state and commit logic. adr_d/wdata_d/op_d always describe the
  // transaction in flight: the live inputs on a capture edge, the captured
  // copy otherwise. That lets a zero-wait access commit on its capture edge.
  always_comb begin
    req        = bus.memread | bus.memwrite;
    state_d    = state_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    op_d       = op_q;
    err_d      = err_q;
    commit     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          adr_d   = bus.adr;
          wdata_d = bus.writedata;
          op_d    = bus.memwrite ? OP_WR : OP_RD;
          cnt_d   = CNT_W'(WAIT_STATES);
          if (bus.memread && bus.memwrite) begin
            err_d = 1'b1;
          end
          if (WAIT_STATES == 0) begin
            state_d = DONE;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Dropping the request mid-wait abandons the access with no side effects.
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    is_io      = (adr_d == IO_ADDR);
    ram_we     = commit && (op_d == OP_WR) && !is_io && !rst;
    io_out_d   = io_out_q;
    readdata_d = readdata_q;
    if (commit) begin
      if (op_d == OP_WR) begin
        if (is_io) begin
          io_out_d = wdata_d;
        end
      end else begin
        readdata_d = is_io ? io_in : ram_rdata;
      end
    end
    memready_d = commit;
  end

  // Control / visible-output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      memready_q <= 1'b0;
      readdata_q <= '0;
      io_out_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      memready_q <= memready_d;
      readdata_q <= readdata_d;
      io_out_q   <= io_out_d;
      err_q      <= err_d;
    end
  end

  // Captured transaction fields; only meaningful while state_q != IDLE.
  always_ff @(posedge clk) begin
    adr_q   <= adr_d;
    wdata_q <= wdata_d;
    op_q    <= op_d;
  end

  byte_ram #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (adr_d[IW-1:0]),
    .wdata (wdata_d),
    .rdata (ram_rdata)
  );

  assign bus.memready = memready_q;
  assign bus.readdata = readdata_q;
  assign io_out       = io_out_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam logic [7:0] IO_A = 8'hFF;

  typedef struct {
    logic [7:0] rd;
    logic [7:0] io;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [7:0] io_in_a, io_in_b, io_out_a, io_out_b;
  logic       err_a, err_b;

  always #5 clk = ~clk;

  mem_responder_if #(.AW(8), .DW(8)) ifa ();
  mem_responder_if #(.AW(8), .DW(8)) ifb ();

  mem_responder #(.AW(8), .DW(8), .DEPTH(256), .WAIT_STATES(0), .IO_ADDR(8'hFF)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa), .io_in(io_in_a), .io_out(io_out_a), .err(err_a)
  );

  mem_responder #(.AW(8), .DW(8), .DEPTH(16), .WAIT_STATES(3), .IO_ADDR(8'hFF)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb), .io_in(io_in_b), .io_out(io_out_b), .err(err_b)
  );

  // Reference model: plain arrays indexed by address modulo depth.
  int         dep [2] = '{256, 16};
  int         ws  [2] = '{0, 3};
  logic [7:0] m_mem [2][256];
  logic [7:0] m_rd  [2];
  logic [7:0] m_io  [2];
  logic       m_err [2];
  bit         in_done [2];

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int passed = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic string nm(int w, string s);
    return $sformatf("%s_%s", (w == 0) ? "a" : "b", s);
  endfunction

  function automatic logic get_ready(int w);
    return (w == 0) ? ifa.memready : ifb.memready;
  endfunction

  function automatic logic [7:0] get_rd(int w);
    return (w == 0) ? ifa.readdata : ifb.readdata;
  endfunction

  task automatic drive(int w, bit rd, bit wr, logic [7:0] a, logic [7:0] d);
    if (w == 0) begin
      ifa.memread = rd; ifa.memwrite = wr; ifa.adr = a; ifa.writedata = d;
    end else begin
      ifb.memread = rd; ifb.memwrite = wr; ifb.adr = a; ifb.writedata = d;
    end
  endtask

  task automatic idle(int w, int k);
    drive(w, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (k) @(negedge clk);
    in_done[w] = 1'b0;
  endtask

  // Issue one access, update the model, push the expected response, and
  // wait (bounded) for memready while checking latency and readdata hold.
  task automatic xact(int w, bit rd, bit wr, logic [7:0] a, logic [7:0] d,
                      logic [7:0] io_v, bit scramble);
    exp_t       e;
    logic [7:0] prev_rd;
    int         n, exp_n, cap_n;
    bit         rdy;
    prev_rd = m_rd[w];
    if (w == 0) io_in_a = io_v; else io_in_b = io_v;
    if (rd && wr) m_err[w] = 1'b1;
    if (wr) begin
      if (a == IO_A) m_io[w] = d;
      else m_mem[w][int'(a) % dep[w]] = d;
    end else begin
      m_rd[w] = (a == IO_A) ? io_v : m_mem[w][int'(a) % dep[w]];
    end
    e.rd = m_rd[w]; e.io = m_io[w]; e.err = m_err[w];
    if (w == 0) q_a.push_back(e); else q_b.push_back(e);
    drive(w, rd, wr, a, d);
    cap_n = in_done[w] ? 2 : 1;
    exp_n = ws[w] + cap_n;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 64) begin
      @(negedge clk);
      n++;
      rdy = get_ready(w);
      if (!rdy) begin
        chk(nm(w, "readdata_hold"), get_rd(w), prev_rd);
        if (scramble && n >= cap_n) drive(w, rd, wr, 8'($urandom), 8'($urandom));
      end
    end
    chk(nm(w, "latency"), n, exp_n);
    in_done[w] = 1'b1;
  endtask

  task automatic abort_b(bit use_rst);
    drive(1, 1'b0, 1'b1, 8'h08, 8'h77);
    repeat (2) begin
      @(negedge clk);
      chk("b_abort_noready", ifb.memready, 1'b0);
    end
    if (use_rst) begin
      rst_b = 1'b1;
      @(negedge clk);
      chk("b_rst_memready", ifb.memready, 1'b0);
      chk("b_rst_readdata", ifb.readdata, 8'h00);
      chk("b_rst_io_out", io_out_b, 8'h00);
      chk("b_rst_err", err_b, 1'b0);
      rst_b = 1'b0;
      m_rd[1] = 8'h00; m_io[1] = 8'h00; m_err[1] = 1'b0;
    end
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (4) begin
      @(negedge clk);
      chk("b_abort_idle", ifb.memready, 1'b0);
    end
    in_done[1] = 1'b0;
  endtask

  task automatic rand_run(int w, int cnt);
    for (int i = 0; i < cnt; i++) begin
      logic [7:0] a;
      bit         rd, wr;
      int         r;
      r  = $urandom_range(0, 9);
      wr = (r < 4);
      rd = !wr;
      if (r == 9) begin rd = 1'b1; wr = 1'b1; end
      if (w == 0) a = ($urandom_range(0, 15) == 0) ? IO_A : 8'($urandom_range(0, 31));
      else        a = 8'($urandom);
      if ($urandom_range(0, 1) == 1) idle(w, $urandom_range(1, 3));
      xact(w, rd, wr, a, 8'($urandom), 8'($urandom),
           (ws[w] > 0) && ($urandom_range(0, 1) == 1));
    end
  endtask

  // Scoreboard monitors: pop and compare on every memready pulse.
  logic prev_a = 1'b0, prev_b = 1'b0;
  exp_t e_a, e_b;

  always @(negedge clk) begin
    if (ifa.memready) begin
      chk("a_pulse_width", prev_a, 1'b0);
      if (q_a.size() == 0) begin
        checks++;
        $display("FAIL a_unexpected_memready: got memready=1 expected no pending access at %0t", $time);
      end else begin
        e_a = q_a.pop_front();
        chk("a_readdata", ifa.readdata, e_a.rd);
        chk("a_io_out", io_out_a, e_a.io);
        chk("a_err", err_a, e_a.err);
      end
    end
    prev_a = ifa.memready;
  end

  always @(negedge clk) begin
    if (ifb.memready) begin
      chk("b_pulse_width", prev_b, 1'b0);
      if (q_b.size() == 0) begin
        checks++;
        $display("FAIL b_unexpected_memready: got memready=1 expected no pending access at %0t", $time);
      end else begin
        e_b = q_b.pop_front();
        chk("b_readdata", ifb.readdata, e_b.rd);
        chk("b_io_out", io_out_b, e_b.io);
        chk("b_err", err_b, e_b.err);
      end
    end
    prev_b = ifb.memready;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected end of run before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    io_in_a = 8'h00; io_in_b = 8'h00;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int w = 0; w < 2; w++) begin
      m_rd[w] = 8'h00; m_io[w] = 8'h00; m_err[w] = 1'b0; in_done[w] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("a_reset_memready", ifa.memready, 1'b0);
    chk("a_reset_readdata", ifa.readdata, 8'h00);
    chk("a_reset_io_out", io_out_a, 8'h00);
    chk("a_reset_err", err_a, 1'b0);
    chk("b_reset_memready", ifb.memready, 1'b0);
    chk("b_reset_readdata", ifb.readdata, 8'h00);
    chk("b_reset_io_out", io_out_b, 8'h00);
    chk("b_reset_err", err_b, 1'b0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // ---- zero wait states, 256-byte RAM ----
    for (int i = 0; i < 32; i++) xact(0, 1'b0, 1'b1, 8'(i), 8'($urandom), 8'h00, 1'b0);
    idle(0, 2);
    xact(0, 1'b0, 1'b1, 8'h10, 8'h5A, 8'h00, 1'b0);
    xact(0, 1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0);
    idle(0, 1);
    xact(0, 1'b0, 1'b1, 8'h00, 8'h11, 8'h00, 1'b0);
    xact(0, 1'b0, 1'b1, 8'h01, 8'h22, 8'h00, 1'b0);
    xact(0, 1'b0, 1'b1, 8'h02, 8'h33, 8'h00, 1'b0);
    xact(0, 1'b0, 1'b1, 8'h03, 8'h44, 8'h00, 1'b0);
    idle(0, 2);
    for (int i = 0; i < 4; i++) xact(0, 1'b1, 1'b0, 8'(i), 8'h00, 8'h00, 1'b0);
    idle(0, 1);
    xact(0, 1'b0, 1'b1, IO_A, 8'hA5, 8'h00, 1'b0);
    xact(0, 1'b1, 1'b0, IO_A, 8'h00, 8'h3C, 1'b0);
    rand_run(0, 150);
    idle(0, 3);

    // ---- three wait states, 16-byte RAM ----
    for (int i = 0; i < 16; i++) xact(1, 1'b0, 1'b1, 8'(i), 8'($urandom), 8'h00, 1'b0);
    idle(1, 2);
    xact(1, 1'b0, 1'b1, 8'h20, 8'hC3, 8'h00, 1'b0);
    idle(1, 1);
    xact(1, 1'b1, 1'b0, 8'h20, 8'h00, 8'h00, 1'b0);
    idle(1, 1);
    xact(1, 1'b0, 1'b1, 8'h00, 8'h11, 8'h00, 1'b0);
    xact(1, 1'b0, 1'b1, 8'h01, 8'h22, 8'h00, 1'b0);
    xact(1, 1'b0, 1'b1, 8'h02, 8'h33, 8'h00, 1'b0);
    xact(1, 1'b0, 1'b1, 8'h03, 8'h44, 8'h00, 1'b0);
    idle(1, 2);
    for (int i = 0; i < 4; i++) xact(1, 1'b1, 1'b0, 8'(i), 8'h00, 8'h00, 1'b1);
    idle(1, 1);
    xact(1, 1'b0, 1'b1, IO_A, 8'hA5, 8'h00, 1'b0);
    xact(1, 1'b1, 1'b0, 8'h0F, 8'h00, 8'h00, 1'b0);
    xact(1, 1'b1, 1'b0, IO_A, 8'h00, 8'h3C, 1'b0);
    idle(1, 2);
    xact(1, 1'b1, 1'b1, 8'h13, 8'h9E, 8'h00, 1'b0);
    idle(1, 1);
    xact(1, 1'b1, 1'b0, 8'h03, 8'h00, 8'h00, 1'b0);
    idle(1, 2);
    abort_b(1'b0);
    xact(1, 1'b1, 1'b0, 8'h08, 8'h00, 8'h00, 1'b0);
    idle(1, 2);
    abort_b(1'b1);
    xact(1, 1'b1, 1'b0, 8'h08, 8'h00, 8'h00, 1'b0);
    rand_run(1, 150);
    idle(1, 3);

    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
